// File: rtl/ahb_multi_master_bridge.sv
// Merges NUM_REQ req/gnt/rvalid requester ports onto a single AHB-Lite master
// with pipelined address/data phases and fixed-priority or round-robin arbitration.
module ahb_multi_master_bridge #(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ARB_MODE = 0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ-1:0]        we_i,
  input  logic [4*NUM_REQ-1:0]      be_i,
  input  logic [ADDR_W*NUM_REQ-1:0] addr_i,
  input  logic [32*NUM_REQ-1:0]     wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        rvalid_o,
  output logic [31:0]               rdata_o,
  output logic [NUM_REQ-1:0]        err_o,
  output logic [1:0]                htrans_o,
  output logic [2:0]                hsize_o,
  output logic [ADDR_W-1:0]         haddr_o,
  output logic [2:0]                hburst_o,
  output logic                      hwrite_o,
  output logic [31:0]               hwdata_o,
  input  logic [31:0]               hrdata_i,
  input  logic                      hready_i,
  input  logic                      hresp_i
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [3:0]        be_a    [NUM_REQ];
  logic [ADDR_W-1:0] addr_a  [NUM_REQ];
  logic [31:0]       wdata_a [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_split
    assign be_a[g]    = be_i[4*g +: 4];
    assign addr_a[g]  = addr_i[ADDR_W*g +: ADDR_W];
    assign wdata_a[g] = wdata_i[32*g +: 32];
  end

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic              any;
  logic              ap_free;
  logic              grant;
  logic [2:0]        sel_size;
  logic [1:0]        sel_off;

  logic              ap_valid;
  logic [IDX_W-1:0]  ap_owner;
  logic [ADDR_W-1:0] ap_addr;
  logic [2:0]        ap_size;
  logic              ap_we;
  logic [31:0]       ap_wdata;

  logic              dp_valid;
  logic [IDX_W-1:0]  dp_owner;
  logic [31:0]       dp_wdata;

  // Round-robin starts the search one past the last winner; fixed mode starts at 0.
  always_comb begin
    int unsigned idx;
    idx = 0;
    win = '0;
    any = 1'b0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = (ARB_MODE == 0) ? off : (32'(ptr) + 1 + off) % NUM_REQ;
      if (!any && req_i[IDX_W'(idx)]) begin
        any = 1'b1;
        win = IDX_W'(idx);
      end
    end
  end

  assign ap_free = !ap_valid || hready_i;
  assign grant   = any && ap_free && !rst_i;
  assign gnt_o   = grant ? (NUM_REQ'(1) << win) : '0;

  always_comb begin
    sel_size = 3'b010;
    sel_off  = 2'b00;
    case (be_a[win])
      4'b0011: sel_size = 3'b001;
      4'b1100: begin sel_size = 3'b001; sel_off = 2'b10; end
      4'b0001: begin sel_size = 3'b000; sel_off = 2'b00; end
      4'b0010: begin sel_size = 3'b000; sel_off = 2'b01; end
      4'b0100: begin sel_size = 3'b000; sel_off = 2'b10; end
      4'b1000: begin sel_size = 3'b000; sel_off = 2'b11; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr      <= IDX_W'(NUM_REQ - 1);
      ap_valid <= 1'b0;
      ap_owner <= '0;
      ap_addr  <= '0;
      ap_size  <= '0;
      ap_we    <= 1'b0;
      ap_wdata <= '0;
    end else if (grant) begin
      ptr      <= win;
      ap_valid <= 1'b1;
      ap_owner <= win;
      ap_addr  <= (addr_a[win] & ~ADDR_W'(3)) | ADDR_W'(sel_off);
      ap_size  <= sel_size;
      ap_we    <= we_i[win];
      ap_wdata <= wdata_a[win];
    end else if (hready_i) begin
      ap_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dp_valid <= 1'b0;
      dp_owner <= '0;
      dp_wdata <= '0;
    end else if (hready_i) begin
      dp_valid <= ap_valid;
      if (ap_valid) begin
        dp_owner <= ap_owner;
        dp_wdata <= ap_wdata;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= '0;
      err_o    <= '0;
      if (dp_valid && hready_i) begin
        rvalid_o[dp_owner] <= 1'b1;
        err_o[dp_owner]    <= hresp_i;
        rdata_o            <= hrdata_i;
      end
    end
  end

  assign htrans_o = ap_valid ? 2'b10 : 2'b00;
  assign haddr_o  = ap_addr;
  assign hsize_o  = ap_size;
  assign hwrite_o = ap_we;
  assign hburst_o = 3'b000;
  assign hwdata_o = dp_wdata;

endmodule

// File: tb/tb_ahb_multi_master_bridge.sv
// Bench for ahb_multi_master_bridge: a fixed-priority and a round-robin instance,
// directed scenarios plus randomized traffic against a transaction-schedule model.
module tb_ahb_multi_master_bridge;

  logic        clk;
  logic        rst;
  logic [1:0]  req    [2];
  logic [1:0]  we     [2];
  logic [7:0]  be     [2];
  logic [63:0] addr   [2];
  logic [63:0] wdata  [2];
  logic [1:0]  gnt    [2];
  logic [1:0]  rvalid [2];
  logic [1:0]  err    [2];
  logic [31:0] rdata  [2];
  logic [1:0]  htrans [2];
  logic [2:0]  hsize  [2];
  logic [31:0] haddr  [2];
  logic [2:0]  hburst [2];
  logic        hwrite [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;

  int checks = 0;
  int errors = 0;

  ahb_multi_master_bridge #(.NUM_REQ(2), .ADDR_W(32), .ARB_MODE(0)) u_fixed (
    .clk_i(clk), .rst_i(rst), .req_i(req[0]), .we_i(we[0]), .be_i(be[0]),
    .addr_i(addr[0]), .wdata_i(wdata[0]), .gnt_o(gnt[0]), .rvalid_o(rvalid[0]),
    .rdata_o(rdata[0]), .err_o(err[0]), .htrans_o(htrans[0]), .hsize_o(hsize[0]),
    .haddr_o(haddr[0]), .hburst_o(hburst[0]), .hwrite_o(hwrite[0]), .hwdata_o(hwdata[0]),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

  ahb_multi_master_bridge #(.NUM_REQ(2), .ADDR_W(32), .ARB_MODE(1)) u_rr (
    .clk_i(clk), .rst_i(rst), .req_i(req[1]), .we_i(we[1]), .be_i(be[1]),
    .addr_i(addr[1]), .wdata_i(wdata[1]), .gnt_o(gnt[1]), .rvalid_o(rvalid[1]),
    .rdata_o(rdata[1]), .err_o(err[1]), .htrans_o(htrans[1]), .hsize_o(hsize[1]),
    .haddr_o(haddr[1]), .hburst_o(hburst[1]), .hwrite_o(hwrite[1]), .hwdata_o(hwdata[1]),
    .hrdata_i(hrdata), .hready_i(hready), .hresp_i(hresp));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < 2; m++) begin
      req[m] = '0; we[m] = '0; be[m] = '0; addr[m] = '0; wdata[m] = '0;
    end
    hrdata = '0; hresp = 1'b0; hready = 1'b1;
  endtask

  task automatic reset_dut();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Size/offset from byte enables: single lane -> byte at that lane,
  // aligned halves -> halfword, everything else -> word.
  function automatic bit [4:0] be_model(input bit [3:0] b);
    if ($countones(b) == 1) begin
      for (int i = 0; i < 4; i++) if (b[i]) return {3'd0, 2'(i)};
    end
    if (b == 4'b0011) return {3'd1, 2'd0};
    if (b == 4'b1100) return {3'd1, 2'd2};
    return {3'd2, 2'd0};
  endfunction

  task automatic test_reset();
    reset_dut();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({gnt[m], rvalid[m], err[m], rdata[m], htrans[m], hsize[m], haddr[m], hburst[m],
           hwrite[m], hwdata[m]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs m=%0d got gnt=%b rv=%b err=%b rdata=%h htrans=%b hsize=%b haddr=%h hwrite=%b hwdata=%h expected all zero",
                 m, gnt[m], rvalid[m], err[m], rdata[m], htrans[m], hsize[m], haddr[m], hwrite[m], hwdata[m]);
      end
    end
    rst = 1'b1;
    req[0] = 2'b11; req[1] = 2'b11;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (gnt[m] !== 2'b00) begin
        errors++; $display("FAIL reset_gnt_forced m=%0d got %b expected 00", m, gnt[m]);
      end
    end
    reset_dut();
  endtask

  task automatic test_single_read();
    reset_dut();
    req[0] = 2'b01; addr[0] = 64'h100; be[0] = 8'h0F; we[0] = 2'b00;
    #1;
    checks++;
    if (gnt[0] !== 2'b01) begin errors++; $display("FAIL read_gnt got %b expected 01", gnt[0]); end
    step();
    req[0] = 2'b00;
    checks++;
    if ({htrans[0], haddr[0], hsize[0], hwrite[0]} !== {2'b10, 32'h100, 3'b010, 1'b0}) begin
      errors++;
      $display("FAIL read_addr_phase got htrans=%b haddr=%h hsize=%b hwrite=%b expected 10/00000100/010/0",
               htrans[0], haddr[0], hsize[0], hwrite[0]);
    end
    step();
    hrdata = 32'hCAFEF00D;
    checks++;
    if (rvalid[0] !== 2'b00) begin errors++; $display("FAIL read_early_rvalid got %b expected 00", rvalid[0]); end
    step();
    hrdata = '0;
    checks++;
    if ({rvalid[0], err[0], rdata[0]} !== {2'b01, 2'b00, 32'hCAFEF00D}) begin
      errors++;
      $display("FAIL read_complete got rv=%b err=%b rdata=%h expected 01/00/cafef00d", rvalid[0], err[0], rdata[0]);
    end
  endtask

  task automatic test_write_be();
    reset_dut();
    req[0] = 2'b10; we[0] = 2'b10; addr[0] = {32'h200, 32'h0}; be[0] = 8'hC0;
    wdata[0] = {32'h12340000, 32'h0};
    #1;
    checks++;
    if (gnt[0] !== 2'b10) begin errors++; $display("FAIL write_gnt got %b expected 10", gnt[0]); end
    step();
    clear_inputs();
    checks++;
    if ({htrans[0], haddr[0], hsize[0], hwrite[0]} !== {2'b10, 32'h202, 3'b001, 1'b1}) begin
      errors++;
      $display("FAIL write_addr_phase got htrans=%b haddr=%h hsize=%b hwrite=%b expected 10/00000202/001/1",
               htrans[0], haddr[0], hsize[0], hwrite[0]);
    end
    step();
    checks++;
    if (hwdata[0] !== 32'h12340000) begin
      errors++; $display("FAIL write_hwdata got %h expected 12340000", hwdata[0]);
    end
    step();
    step();
  endtask

  task automatic test_fixed_priority();
    reset_dut();
    req[0] = 2'b11; addr[0] = {32'h2000, 32'h1000}; be[0] = 8'hFF;
    #1;
    checks++;
    if (gnt[0] !== 2'b01) begin errors++; $display("FAIL fixed_first_gnt got %b expected 01", gnt[0]); end
    step();
    req[0] = 2'b10;
    checks++;
    if ({htrans[0], haddr[0]} !== {2'b10, 32'h1000}) begin
      errors++; $display("FAIL fixed_bus0 got htrans=%b haddr=%h expected 10/00001000", htrans[0], haddr[0]);
    end
    #1;
    checks++;
    if (gnt[0] !== 2'b10) begin errors++; $display("FAIL fixed_second_gnt got %b expected 10", gnt[0]); end
    step();
    req[0] = 2'b00;
    checks++;
    if ({htrans[0], haddr[0]} !== {2'b10, 32'h2000}) begin
      errors++; $display("FAIL fixed_bus1 got htrans=%b haddr=%h expected 10/00002000", htrans[0], haddr[0]);
    end
    step(); step(); step();
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 0, 1, 0, 1};
    reset_dut();
    req[1] = 2'b11; be[1] = 8'hFF;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++;
      if (gnt[1] !== 2'(1 << order[i])) begin
        errors++; $display("FAIL rr_order grant %0d got %b expected %b", i, gnt[1], 2'(1 << order[i]));
      end
      step();
    end
    req[1] = 2'b00;
    step(); step(); step();
  endtask

  task automatic test_stall_error();
    reset_dut();
    req[0] = 2'b11; addr[0] = {32'h80, 32'h40}; be[0] = 8'hFF; we[0] = 2'b10;
    wdata[0] = {32'hA5A50001, 32'h11110000};
    #1;
    checks++;
    if (gnt[0] !== 2'b01) begin errors++; $display("FAIL stall_gnt0 got %b expected 01", gnt[0]); end
    step();
    req[0] = 2'b10;
    #1;
    checks++;
    if (gnt[0] !== 2'b10) begin errors++; $display("FAIL stall_gnt1 got %b expected 10", gnt[0]); end
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin
        req[0] = 2'b01; addr[0] = {32'h80, 32'hC0}; we[0] = 2'b00; hready = 1'b0;
      end
      if (i == 3) begin
        hready = 1'b1; hrdata = 32'hDEAD0001; hresp = 1'b1;
      end
      checks++;
      if ({htrans[0], haddr[0], hwrite[0], hwdata[0], rvalid[0]} !== {2'b10, 32'h80, 1'b1, 32'h11110000, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got htrans=%b haddr=%h hwrite=%b hwdata=%h rv=%b expected 10/00000080/1/11110000/00",
                 i, htrans[0], haddr[0], hwrite[0], hwdata[0], rvalid[0]);
      end
      #1;
      checks++;
      if (gnt[0] !== ((i == 3) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL stall_gnt cycle %0d got %b expected %b", i, gnt[0], (i == 3) ? 2'b01 : 2'b00);
      end
      step();
    end
    req[0] = 2'b00; hresp = 1'b0; hrdata = '0;
    checks++;
    if ({rvalid[0], err[0], rdata[0], haddr[0], hwdata[0]} !== {2'b01, 2'b01, 32'hDEAD0001, 32'hC0, 32'hA5A50001}) begin
      errors++;
      $display("FAIL stall_complete got rv=%b err=%b rdata=%h haddr=%h hwdata=%h expected 01/01/dead0001/000000c0/a5a50001",
               rvalid[0], err[0], rdata[0], haddr[0], hwdata[0]);
    end
    step();
    checks++;
    if ({rvalid[0], err[0]} !== {2'b10, 2'b00}) begin
      errors++; $display("FAIL stall_next_write got rv=%b err=%b expected 10/00", rvalid[0], err[0]);
    end
    step();
    checks++;
    if ({rvalid[0], err[0]} !== {2'b01, 2'b00}) begin
      errors++; $display("FAIL stall_last_read got rv=%b err=%b expected 01/00", rvalid[0], err[0]);
    end
    step();
  endtask

  task automatic test_reset_mid_transfer();
    reset_dut();
    for (int m = 0; m < 2; m++) begin
      req[m] = 2'b11; addr[m] = {32'h20, 32'h10}; be[m] = 8'hFF;
    end
    step();
    for (int m = 0; m < 2; m++) req[m] = 2'b10;
    step();
    // AP holds requester 1, DP holds requester 0 here
    for (int m = 0; m < 2; m++) req[m] = 2'b11;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (rvalid[m] !== ((c == 3) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00)) begin
          errors++; $display("FAIL rst_mid_rvalid m=%0d cycle %0d got %b", m, c, rvalid[m]);
        end
        if (c == 0) begin
          checks++;
          if (htrans[m] !== 2'b00) begin
            errors++; $display("FAIL rst_mid_htrans m=%0d got %b expected 00", m, htrans[m]);
          end
        end
      end
      #1;
      if (c == 0) begin
        for (int m = 0; m < 2; m++) begin
          checks++;
          if (gnt[m] !== 2'b01) begin
            errors++; $display("FAIL rst_mid_first_gnt m=%0d got %b expected 01", m, gnt[m]);
          end
        end
      end
      step();
      for (int m = 0; m < 2; m++) req[m] = (c == 0) ? 2'b10 : 2'b00;
    end
  endtask

  // Randomized traffic with hready held high: each grant appears on the bus one
  // cycle later, in the data phase two cycles later and completes three cycles later.
  task automatic test_random(input int m, input int tn);
    bit        ap_v [0:199];
    bit [31:0] ap_a [0:199];
    bit [2:0]  ap_s [0:199];
    bit        ap_w [0:199];
    bit        dp_v [0:199];
    bit [31:0] dp_d [0:199];
    int        dp_o [0:199];
    bit        rv   [0:199];
    int        rv_o [0:199];
    bit [31:0] rv_d [0:199];
    bit        rv_e [0:199];
    bit        pend [2];
    bit [31:0] pa   [2];
    bit [31:0] pd   [2];
    bit [3:0]  pb   [2];
    bit        pw   [2];
    bit [3:0]  tbl  [8];
    bit [4:0]  sz;
    bit [1:0]  exp_rv;
    bit [1:0]  exp_er;
    bit [1:0]  exp_g;
    int        ptr;
    int        w;
    int        t;
    tbl = '{4'hF, 4'h3, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    for (int i = 0; i < 200; i++) begin
      ap_v[i] = 0; ap_a[i] = 0; ap_s[i] = 0; ap_w[i] = 0; dp_v[i] = 0; dp_d[i] = 0;
      dp_o[i] = 0; rv[i] = 0; rv_o[i] = 0; rv_d[i] = 0; rv_e[i] = 0;
    end
    for (int k = 0; k < 2; k++) begin pend[k] = 0; pa[k] = 0; pd[k] = 0; pb[k] = 0; pw[k] = 0; end
    reset_dut();
    ptr = 1;
    for (int c = 0; c < tn + 4; c++) begin
      exp_rv = rv[c] ? 2'(1 << rv_o[c]) : 2'b00;
      exp_er = (rv[c] && rv_e[c]) ? exp_rv : 2'b00;
      checks++;
      if (htrans[m] !== (ap_v[c] ? 2'b10 : 2'b00)) begin
        errors++; $display("FAIL rand_htrans m=%0d c=%0d got %b expected %b", m, c, htrans[m], ap_v[c] ? 2'b10 : 2'b00);
      end
      if (ap_v[c]) begin
        checks++;
        if ({haddr[m], hsize[m], hwrite[m]} !== {ap_a[c], ap_s[c], ap_w[c]}) begin
          errors++;
          $display("FAIL rand_addr_phase m=%0d c=%0d got haddr=%h hsize=%b hwrite=%b expected %h/%b/%b",
                   m, c, haddr[m], hsize[m], hwrite[m], ap_a[c], ap_s[c], ap_w[c]);
        end
      end
      if (dp_v[c]) begin
        checks++;
        if (hwdata[m] !== dp_d[c]) begin
          errors++; $display("FAIL rand_hwdata m=%0d c=%0d got %h expected %h", m, c, hwdata[m], dp_d[c]);
        end
      end
      checks++;
      if ({rvalid[m], err[m]} !== {exp_rv, exp_er}) begin
        errors++;
        $display("FAIL rand_resp m=%0d c=%0d got rv=%b err=%b expected %b/%b", m, c, rvalid[m], err[m], exp_rv, exp_er);
      end
      if (rv[c]) begin
        checks++;
        if (rdata[m] !== rv_d[c]) begin
          errors++; $display("FAIL rand_rdata m=%0d c=%0d got %h expected %h", m, c, rdata[m], rv_d[c]);
        end
      end
      for (int k = 0; k < 2; k++) begin
        if (c < tn && !pend[k] && $urandom_range(0, 2) != 0) begin
          pend[k] = 1;
          pa[k] = $urandom() & 32'hFFFF_FFFC;
          pd[k] = $urandom();
          pw[k] = 1'($urandom_range(0, 1));
          t = $urandom_range(0, 9);
          pb[k] = (t < 8) ? tbl[t] : 4'($urandom());
        end
        req[m][k] = pend[k];
        we[m][k] = pw[k];
        be[m][4*k +: 4] = pb[k];
        addr[m][32*k +: 32] = pa[k];
        wdata[m][32*k +: 32] = pd[k];
      end
      hrdata = $urandom();
      hresp = ($urandom_range(0, 3) == 0);
      if (dp_v[c]) begin
        rv[c+1] = 1; rv_o[c+1] = dp_o[c]; rv_d[c+1] = hrdata; rv_e[c+1] = hresp;
      end
      #1;
      w = -1;
      for (int i = 0; i < 2; i++) begin
        t = (m == 0) ? i : (ptr + 1 + i) % 2;
        if (w < 0 && pend[t]) w = t;
      end
      exp_g = (w >= 0) ? 2'(1 << w) : 2'b00;
      checks++;
      if (gnt[m] !== exp_g) begin
        errors++; $display("FAIL rand_gnt m=%0d c=%0d got %b expected %b", m, c, gnt[m], exp_g);
      end
      if (w >= 0) begin
        sz = be_model(pb[w]);
        ap_v[c+1] = 1; ap_a[c+1] = {pa[w][31:2], sz[1:0]}; ap_s[c+1] = sz[4:2]; ap_w[c+1] = pw[w];
        dp_v[c+2] = 1; dp_d[c+2] = pd[w]; dp_o[c+2] = w;
        pend[w] = 0;
        if (m == 1) ptr = w;
      end
      step();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_write_be();
    test_fixed_priority();
    test_round_robin();
    test_stall_error();
    test_reset_mid_transfer();
    test_random(0, 80);
    test_random(1, 80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
